// File: rtl/switch_debounce.sv
// switch_debounce
//   Conditions the board slide switches for the PIO in_port: each raw bit is
//   brought into clk through a two-flop synchronizer and then debounced with
//   its own stability counter. A new level is accepted only after it has held
//   for DEBOUNCE_CYCLES consecutive synchronized cycles.
//
//   Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN
//     defined   -> registered one-cycle sw_rise / sw_fall / sw_changed pulses
//     undefined -> pulse ports kept but tied to 0, no pulse flops built
//
//   Reset: reset_n, asynchronous, active-low. It clears every register,
//   including any count in progress.
module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Terminal count: a differing level that is seen while the counter already
  // holds this value has been stable for DEBOUNCE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronizer stages (no logic between them).
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Debounced level and per-bit stability counters.
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce rule: restart on agreement, count on disagreement,
  // accept the new level once the count reaches the terminal value.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = s2_q[i];
        cnt_d[i]   = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounced level and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      clean_q <= clean_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_clean = clean_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  // Edge detect on the committing level so the pulse lines up with the
  // first cycle the new sw_clean is visible.
  always_comb begin
    rise_d    = clean_d & ~clean_q;
    fall_d    = ~clean_d & clean_q;
    changed_d = |(rise_d | fall_d);
  end

  // Pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;
`else
  assign sw_rise    = '0;
  assign sw_fall    = '0;
  assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce (WIDTH=8, DEBOUNCE_CYCLES=4).
// A reference model built on a sliding window of sampled raw values predicts
// the outputs after every edge; a monitor pops the predictions and compares.
module tb_switch_debounce;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int checks   = 0;
  int failures = 0;

  exp_t         exp_q[$];
  logic [W-1:0] hist [D+2];   // hist[0] = raw sampled at latest edge
  logic [W-1:0] clean_m;

  switch_debounce #(.WIDTH(W), .CNT_W(16), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < D + 2; j++) hist[j] = '0;
    clean_m = '0;
  endtask

  // Asynchronous reset wipes the model immediately.
  always @(negedge reset_n) model_clear();

  // Reference model: a bit takes a new level when the last D synchronized
  // samples (raw delayed by two edges) all disagree with the current level.
  initial begin
    exp_t e;
    logic [W-1:0] commit, nxt;
    model_clear();
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        model_clear();
        e = '0;
      end else begin
        for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = sw_raw;
        commit = '1;
        for (int j = 2; j < D + 2; j++) commit &= (hist[j] ^ clean_m);
        nxt = clean_m ^ commit;
        e.clean = nxt;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        e.rise    = nxt & ~clean_m;
        e.fall    = ~nxt & clean_m;
        e.changed = |commit;
`else
        e.rise    = '0;
        e.fall    = '0;
        e.changed = 1'b0;
`endif
        clean_m = nxt;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!reset_n) e = '0;   // reset overrides anything predicted earlier
        check("sw_clean",   sw_clean,         e.clean);
        check("sw_rise",    sw_rise,          e.rise);
        check("sw_fall",    sw_fall,          e.fall);
        check("sw_changed", W'(sw_changed),   W'(e.changed));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [W-1:0] v, input int n);
    sw_raw = v;
    step(n);
  endtask

  initial begin
    reset_n = 1'b0;
    sw_raw  = 8'hFF;
    step(3);
    reset_n = 1'b1;
    // switches held high through reset: accepted as a normal rise
    drive(8'hFF, 12);
    drive(8'h00, 12);
    // clean step on bit 3
    drive(8'h08, 12);
    drive(8'h00, 12);
    // glitch on bit 0 shorter than the debounce window
    drive(8'h01, 3);
    drive(8'h00, 20);
    // bounce on bit 5
    drive(8'h20, 1);
    drive(8'h00, 1);
    drive(8'h20, 2);
    drive(8'h00, 1);
    drive(8'h20, 12);
    drive(8'h00, 12);
    // simultaneous rise of bit 1 and fall of bit 7
    drive(8'h80, 12);
    drive(8'h02, 12);
    // same, but reset hits while both bits are pending
    drive(8'h80, 12);
    drive(8'h02, 4);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    drive(8'h02, 12);
    // random segments of varying hold length
    for (int k = 0; k < 300; k++) begin
      drive(W'($urandom), int'($urandom_range(1, 7)));
    end
    // occasional random mid-operation reset
    for (int k = 0; k < 10; k++) begin
      drive(W'($urandom), int'($urandom_range(1, 6)));
      reset_n = 1'b0;
      step(int'($urandom_range(1, 2)));
      reset_n = 1'b1;
      drive(W'($urandom), 10);
    end
    step(2);
    check("scoreboard_backlog", W'(exp_q.size() > 1), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
